// File: rtl/csr_access_sequencer.sv
// Zicsr instruction sequencer: runs one CSRRW/S/C(I) as a fixed
// read-then-write operation against the CSR file. It performs the
// legality checks and returns the old CSR value plus an illegal flag.
module csr_access_sequencer #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_rs1_val,
  input  logic [4:0]        req_rs1_idx,
  input  logic [4:0]        req_rd_idx,
  input  logic [1:0]        priv_mode,
  input  logic              flush,
  output logic              csr_rd_en,
  output logic [ADDR_W-1:0] csr_addr,
  input  logic [XLEN-1:0]   csr_rdata,
  input  logic              csr_rd_illegal,
  output logic              csr_wr_en,
  output logic [XLEN-1:0]   csr_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_illegal
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  state_t state;

  // Request fields captured at accept
  logic [1:0]      op_p0;
  logic [XLEN-1:0] src_p0;
  logic            read_req_p0;
  logic            write_req_p0;
  logic            illegal_p0;

  // Old CSR value captured in READ
  logic [XLEN-1:0] old_val_p1;

  // Write strobe armed at the end of READ; flush/reset can still veto it
  logic            wr_en_q;

  logic            accept;
  logic [XLEN-1:0] src_in;
  logic            write_req_in;
  logic            read_req_in;
  logic            dec_illegal_in;
  logic            rd_fault;

  // Read-modify-write combine for the three CSR operations
  function automatic logic [XLEN-1:0] csr_combine(input logic [1:0]      op,
                                                  input logic [XLEN-1:0] old_val,
                                                  input logic [XLEN-1:0] src);
    logic [XLEN-1:0] res;
    res = src;
    case (op)
      OP_RS:   res = old_val | src;
      OP_RC:   res = old_val & ~src;
      default: res = src;
    endcase
    return res;
  endfunction

  // Decode-time legality: bad funct3, insufficient privilege, write to read-only
  function automatic logic decode_illegal(input logic [1:0]        op,
                                          input logic [ADDR_W-1:0] addr,
                                          input logic [1:0]        priv,
                                          input logic              write_req);
    logic bad_op;
    logic bad_priv;
    logic bad_ro;
    bad_op   = (op == 2'b00);
    bad_priv = (addr[9:8] > priv);
    bad_ro   = write_req && (addr[11:10] == 2'b11);
    return bad_op || bad_priv || bad_ro;
  endfunction

  assign accept         = req_valid && req_ready && !flush;
  assign src_in         = req_funct3[2] ? XLEN'(req_rs1_idx) : req_rs1_val;
  assign write_req_in   = (req_funct3[1:0] == OP_RW) || (src_in != '0);
  assign read_req_in    = (req_funct3[1:0] != OP_RW) || (req_rd_idx != 5'd0);
  assign dec_illegal_in = decode_illegal(req_funct3[1:0], req_addr, priv_mode, write_req_in);
  assign rd_fault       = csr_rd_en && csr_rd_illegal;
  assign csr_wr_en      = wr_en_q && !flush && !reset;

  // Sequencer FSM with registered control and response outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      req_ready    <= 1'b1;
      csr_rd_en    <= 1'b0;
      csr_addr     <= '0;
      wr_en_q      <= 1'b0;
      csr_wdata    <= '0;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      resp_illegal <= 1'b0;
      read_req_p0  <= 1'b0;
      write_req_p0 <= 1'b0;
      illegal_p0   <= 1'b0;
    end else begin
      case (state)
        // stage p0: accept and decode
        IDLE: begin
          if (accept) begin
            state        <= READ;
            req_ready    <= 1'b0;
            csr_addr     <= req_addr;
            read_req_p0  <= read_req_in;
            write_req_p0 <= write_req_in;
            illegal_p0   <= dec_illegal_in;
            // CSRRW rd=x0 still probes so an unimplemented address faults
            csr_rd_en    <= !dec_illegal_in;
          end
        end
        // stage p1: CSR read and existence probe
        READ: begin
          csr_rd_en <= 1'b0;
          if (flush) begin
            state     <= IDLE;
            req_ready <= 1'b1;
          end else begin
            state      <= WRITE;
            illegal_p0 <= illegal_p0 || rd_fault;
            wr_en_q    <= write_req_p0 && !illegal_p0 && !rd_fault;
            csr_wdata  <= csr_combine(op_p0, csr_rdata, src_p0);
          end
        end
        // stage p2: CSR write
        WRITE: begin
          wr_en_q <= 1'b0;
          if (flush) begin
            state     <= IDLE;
            req_ready <= 1'b1;
          end else begin
            state        <= RESP;
            resp_valid   <= 1'b1;
            resp_illegal <= illegal_p0;
            resp_rdata   <= illegal_p0 ? '0 : old_val_p1;
          end
        end
        // stage p3: hold response until consumed
        RESP: begin
          if (flush || resp_ready) begin
            state        <= IDLE;
            req_ready    <= 1'b1;
            resp_valid   <= 1'b0;
            resp_illegal <= 1'b0;
            resp_rdata   <= '0;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          csr_rd_en <= 1'b0;
          wr_en_q   <= 1'b0;
        end
      endcase
    end
  end

  // Datapath capture of operands and old value (no reset needed)
  always_ff @(posedge clock) begin
    if (accept) begin
      op_p0  <= req_funct3[1:0];
      src_p0 <= src_in;
    end
    if (state == READ) begin
      old_val_p1 <= read_req_p0 ? csr_rdata : '0;
    end
  end

endmodule

// File: tb/tb_csr_access_sequencer.sv
// Self-checking bench for csr_access_sequencer: directed vector table,
// multi-cycle corner sequences and randomized ops against a reference model.
module tb_csr_access_sequencer;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [11:0] req_addr;
  logic [31:0] req_rs1_val;
  logic [4:0]  req_rs1_idx;
  logic [4:0]  req_rd_idx;
  logic [1:0]  priv_mode;
  logic        flush;
  logic        csr_rd_en;
  logic [11:0] csr_addr;
  logic [31:0] csr_rdata;
  logic        csr_rd_illegal;
  logic        csr_wr_en;
  logic [31:0] csr_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_illegal;

  int total = 0;
  int bad   = 0;

  csr_access_sequencer #(.XLEN(32), .ADDR_W(12)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_funct3(req_funct3), .req_addr(req_addr),
    .req_rs1_val(req_rs1_val), .req_rs1_idx(req_rs1_idx), .req_rd_idx(req_rd_idx),
    .priv_mode(priv_mode), .flush(flush),
    .csr_rd_en(csr_rd_en), .csr_addr(csr_addr),
    .csr_rdata(csr_rdata), .csr_rd_illegal(csr_rd_illegal),
    .csr_wr_en(csr_wr_en), .csr_wdata(csr_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_illegal(resp_illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [2:0]  f3;
    logic [11:0] addr;
    logic [31:0] rs1v;
    logic [4:0]  rs1i;
    logic [4:0]  rdi;
    logic [1:0]  priv;
    logic [31:0] rdata;
    logic        rdill;
    exp_t        e;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference: outcome of one CSR instruction given the CSR file's answer
  function automatic exp_t ref_model(input logic [2:0] f3, input logic [11:0] addr,
                                     input logic [31:0] rs1v, input logic [4:0] rs1i,
                                     input logic [4:0] rdi, input logic [1:0] priv,
                                     input logic [31:0] rdata, input logic rdill);
    exp_t r;
    int unsigned kind, src, old;
    bit writes, dec_bad;
    kind    = f3[1:0];
    src     = f3[2] ? {27'd0, rs1i} : rs1v;
    old     = rdata;
    writes  = (kind == 1) || (src != 0);
    dec_bad = (kind == 0) || (addr[9:8] > priv) || (writes && addr[11:10] == 2'b11);
    r.rd    = !dec_bad;
    r.ill   = dec_bad || rdill;
    r.wr    = writes && !r.ill;
    if (kind == 1)      r.wdata = src;
    else if (kind == 2) r.wdata = old | src;
    else                r.wdata = old & ~src;
    if (r.ill || (kind == 1 && rdi == 0)) r.rdata = 0;
    else                                  r.rdata = old;
    return r;
  endfunction

  task automatic wait_ready();
    int w = 0;
    while (!req_ready && w < 10) begin
      @(negedge clock);
      w++;
    end
    check("req_ready_wait", {31'd0, req_ready}, 32'd1);
  endtask

  // Present one request at a negedge (cycle N); returns at the negedge of N+1
  task automatic drive_req(input logic [2:0] f3, input logic [11:0] addr,
                           input logic [31:0] rs1v, input logic [4:0] rs1i,
                           input logic [4:0] rdi, input logic [1:0] priv,
                           input logic [31:0] rdata, input logic rdill);
    wait_ready();
    req_funct3     = f3;
    req_addr       = addr;
    req_rs1_val    = rs1v;
    req_rs1_idx    = rs1i;
    req_rd_idx     = rdi;
    priv_mode      = priv;
    csr_rdata      = rdata;
    csr_rd_illegal = rdill;
    req_valid      = 1'b1;
    @(negedge clock);
    req_valid      = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] f3, input logic [11:0] addr,
                        input logic [31:0] rs1v, input logic [4:0] rs1i,
                        input logic [4:0] rdi, input logic [1:0] priv,
                        input logic [31:0] rdata, input logic rdill,
                        input exp_t e, input int stall);
    logic [31:0] held;
    drive_req(f3, addr, rs1v, rs1i, rdi, priv, rdata, rdill);
    // N+1: read strobe
    check("n1_rd_en", {31'd0, csr_rd_en}, {31'd0, e.rd});
    check("n1_wr_en", {31'd0, csr_wr_en}, 32'd0);
    check("n1_addr", {20'd0, csr_addr}, {20'd0, addr});
    check("n1_req_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clock);
    // N+2: write strobe
    check("n2_rd_en", {31'd0, csr_rd_en}, 32'd0);
    check("n2_wr_en", {31'd0, csr_wr_en}, {31'd0, e.wr});
    if (e.wr) check("n2_wdata", csr_wdata, e.wdata);
    check("n2_resp_valid", {31'd0, resp_valid}, 32'd0);
    resp_ready = (stall == 0);
    @(negedge clock);
    // N+3: response
    check("n3_resp_valid", {31'd0, resp_valid}, 32'd1);
    check("n3_resp_rdata", resp_rdata, e.rdata);
    check("n3_resp_illegal", {31'd0, resp_illegal}, {31'd0, e.ill});
    check("n3_wr_en", {31'd0, csr_wr_en}, 32'd0);
    held = resp_rdata;
    for (int k = 0; k < stall; k++) begin
      @(negedge clock);
      check("stall_resp_valid", {31'd0, resp_valid}, 32'd1);
      check("stall_resp_rdata", resp_rdata, held);
      check("stall_resp_illegal", {31'd0, resp_illegal}, {31'd0, e.ill});
      check("stall_req_ready", {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clock);
    check("post_req_ready", {31'd0, req_ready}, 32'd1);
    check("post_resp_valid", {31'd0, resp_valid}, 32'd0);
  endtask

  vec_t vecs[13];

  initial begin
    exp_t e;
    // {f3, addr, rs1v, rs1i, rdi, priv, rdata, rdill, {rd, wr, wdata, rdata, ill}}
    vecs[0]  = '{3'b010, 12'hC00, 32'h0,        5'd0, 5'd5, 2'd0, 32'h1234, 1'b0, '{1'b1, 1'b0, 32'h0,        32'h1234, 1'b0}};
    vecs[1]  = '{3'b001, 12'h340, 32'hDEADBEEF, 5'd1, 5'd1, 2'd3, 32'h5,    1'b0, '{1'b1, 1'b1, 32'hDEADBEEF, 32'h5,    1'b0}};
    vecs[2]  = '{3'b111, 12'h340, 32'hAAAA,     5'd3, 5'd2, 2'd3, 32'hFF,   1'b0, '{1'b1, 1'b1, 32'hFC,       32'hFF,   1'b0}};
    vecs[3]  = '{3'b101, 12'hC01, 32'h0,        5'd4, 5'd3, 2'd0, 32'h77,   1'b0, '{1'b0, 1'b0, 32'h0,        32'h0,    1'b1}};
    vecs[4]  = '{3'b010, 12'h300, 32'h1,        5'd1, 5'd4, 2'd0, 32'h88,   1'b0, '{1'b0, 1'b0, 32'h0,        32'h0,    1'b1}};
    vecs[5]  = '{3'b001, 12'h7FF, 32'h9,        5'd1, 5'd1, 2'd3, 32'h66,   1'b1, '{1'b1, 1'b0, 32'h0,        32'h0,    1'b1}};
    vecs[6]  = '{3'b000, 12'h340, 32'h1,        5'd1, 5'd1, 2'd3, 32'h44,   1'b0, '{1'b0, 1'b0, 32'h0,        32'h0,    1'b1}};
    vecs[7]  = '{3'b001, 12'h340, 32'h11,       5'd2, 5'd0, 2'd3, 32'h99,   1'b0, '{1'b1, 1'b1, 32'h11,       32'h0,    1'b0}};
    vecs[8]  = '{3'b010, 12'h340, 32'hF0,       5'd2, 5'd0, 2'd3, 32'h0F,   1'b0, '{1'b1, 1'b1, 32'hFF,       32'h0F,   1'b0}};
    vecs[9]  = '{3'b110, 12'hC00, 32'h5,        5'd0, 5'd1, 2'd0, 32'hCAFE, 1'b0, '{1'b1, 1'b0, 32'h0,        32'hCAFE, 1'b0}};
    vecs[10] = '{3'b111, 12'hC02, 32'h5,        5'd0, 5'd7, 2'd1, 32'hBEEF, 1'b0, '{1'b1, 1'b0, 32'h0,        32'hBEEF, 1'b0}};
    vecs[11] = '{3'b010, 12'h100, 32'h2,        5'd9, 5'd8, 2'd1, 32'h5,    1'b0, '{1'b1, 1'b1, 32'h7,        32'h5,    1'b0}};
    vecs[12] = '{3'b011, 12'h200, 32'h2,        5'd9, 5'd8, 2'd1, 32'h5,    1'b0, '{1'b0, 1'b0, 32'h0,        32'h0,    1'b1}};

    reset = 1'b1; req_valid = 1'b0; req_funct3 = '0; req_addr = '0;
    req_rs1_val = '0; req_rs1_idx = '0; req_rd_idx = '0; priv_mode = '0;
    flush = 1'b0; csr_rdata = '0; csr_rd_illegal = 1'b0; resp_ready = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_illegal", {31'd0, resp_illegal}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_rd_en", {31'd0, csr_rd_en}, 32'd0);
    check("rst_wr_en", {31'd0, csr_wr_en}, 32'd0);
    check("rst_wdata", csr_wdata, 32'd0);
    check("rst_addr", {20'd0, csr_addr}, 32'd0);

    // Directed vector table
    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].f3, vecs[i].addr, vecs[i].rs1v, vecs[i].rs1i, vecs[i].rdi,
             vecs[i].priv, vecs[i].rdata, vecs[i].rdill, vecs[i].e, 0);
    end

    // Back-pressure: resp_ready low for 4 response cycles
    run_op(vecs[1].f3, vecs[1].addr, vecs[1].rs1v, vecs[1].rs1i, vecs[1].rdi,
           vecs[1].priv, vecs[1].rdata, vecs[1].rdill, vecs[1].e, 4);

    // Flush during WRITE: strobe suppressed, back to IDLE, no response
    drive_req(3'b001, 12'h340, 32'h1234_5678, 5'd1, 5'd1, 2'd3, 32'h5, 1'b0);
    @(negedge clock);
    flush = 1'b1;
    #1;
    check("flush_wr_wr_en", {31'd0, csr_wr_en}, 32'd0);
    @(negedge clock);
    flush = 1'b0;
    check("flush_wr_req_ready", {31'd0, req_ready}, 32'd1);
    check("flush_wr_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("flush_wr_wr_en_after", {31'd0, csr_wr_en}, 32'd0);

    // Flush during READ: no write follows
    drive_req(3'b001, 12'h340, 32'h1, 5'd1, 5'd1, 2'd3, 32'h5, 1'b0);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    check("flush_rd_wr_en", {31'd0, csr_wr_en}, 32'd0);
    check("flush_rd_req_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clock);
    check("flush_rd_resp_valid", {31'd0, resp_valid}, 32'd0);

    // Flush in IDLE blocks acceptance
    req_funct3 = 3'b001; req_addr = 12'h340; priv_mode = 2'd3;
    req_valid = 1'b1; flush = 1'b1;
    @(negedge clock);
    req_valid = 1'b0; flush = 1'b0;
    check("flush_idle_rd_en", {31'd0, csr_rd_en}, 32'd0);
    check("flush_idle_req_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clock);
    check("flush_idle_wr_en", {31'd0, csr_wr_en}, 32'd0);

    // Reset while in READ
    drive_req(3'b001, 12'h340, 32'hFFFF_0000, 5'd1, 5'd1, 2'd3, 32'h5, 1'b0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("rstmid_req_ready", {31'd0, req_ready}, 32'd1);
    check("rstmid_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rstmid_resp_illegal", {31'd0, resp_illegal}, 32'd0);
    check("rstmid_resp_rdata", resp_rdata, 32'd0);
    check("rstmid_rd_en", {31'd0, csr_rd_en}, 32'd0);
    check("rstmid_wr_en", {31'd0, csr_wr_en}, 32'd0);
    check("rstmid_wdata", csr_wdata, 32'd0);
    check("rstmid_addr", {20'd0, csr_addr}, 32'd0);
    @(negedge clock);
    check("rstmid_wr_en_later", {31'd0, csr_wr_en}, 32'd0);

    // Randomized ops against the reference model
    for (int n = 0; n < 200; n++) begin
      logic [2:0]  f3;
      logic [11:0] addr;
      logic [31:0] rs1v, rdata;
      logic [4:0]  rs1i, rdi;
      logic [1:0]  priv;
      logic        rdill;
      int          pr;
      f3    = 3'($urandom_range(0, 7));
      addr  = 12'($urandom);
      rs1v  = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom);
      rs1i  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      rdi   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      pr    = $urandom_range(0, 2);
      priv  = (pr == 2) ? 2'd3 : 2'(pr);
      rdata = 32'($urandom);
      rdill = ($urandom_range(0, 7) == 0);
      e = ref_model(f3, addr, rs1v, rs1i, rdi, priv, rdata, rdill);
      run_op(f3, addr, rs1v, rs1i, rdi, priv, rdata, rdill, e, $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
